tick_gen_multi: RTL and testbench

- Parametrised successor to the fixed UART/front-panel clock generator.
- Free-running prescaler plus binary counter feeding NCH independent tick channels. Each channel selects a counter tap at run time and emits a one-cycle rising-edge strobe plus a registered level.
- Adds a run-time loadable prescale divisor and a sync restart, used by the UART for start-bit phase alignment.
- Sits at top level; drives the UART baud oversample, front-panel refresh and button-delay consumers.

---
 rtl/tick_gen_multi_pkg.sv | 13 +
 rtl/tick_gen_multi_tick_chan.sv | 68 ++++++
 rtl/tick_gen_multi.sv | 76 +++++++
 tb/tb_tick_gen_multi.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tick_gen_multi_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package tick_gen_multi_pkg;

  localparam int DEF_PREDIV = 23;
  localparam int DEF_CNT_W  = 17;
  localparam int DIV_MIN    = 1;

  // Low bit of channel ch's field inside the packed tap-select bus.
  function automatic int tap_lo(input int ch, input int tap_w);
    return ch * tap_w;
  endfunction

endpackage

// File: rtl/tick_gen_multi_tick_chan.sv
// One tick channel: tap mux, level register and edge strobes with tap-change suppression.
// Falling-edge strobe is built only when TICKGEN_FALL_EN is defined.
module tick_chan
  import tick_gen_multi_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TAP_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] cnt,
  input  logic [TAP_W-1:0] tap,
  output logic             tick,
  output logic             lvl,
  output logic             tick_fall
);

  logic             sel;
  logic             changed;
  logic             lvl_d, lvl_q;
  logic             tick_d, tick_q;
  logic [TAP_W-1:0] tap_d, tap_q;

  // Taps at or beyond CNT_W match no counter bit, so the channel reads 0.
  always_comb begin
    sel = 1'b0;
    for (int b = 0; b < CNT_W; b++) begin
      if (32'(tap) == b) sel = cnt[b];
    end
    changed = (tap != tap_q);
    tap_d   = tap;
    lvl_d   = clear ? 1'b0 : sel;
    tick_d  = (clear || changed) ? 1'b0 : (sel & ~lvl_q);
  end

  always_ff @(posedge clk) begin
    tap_q <= tap_d;
    if (reset) begin
      lvl_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
  assign lvl  = lvl_q;

`ifdef TICKGEN_FALL_EN
  logic fall_d, fall_q;

  always_comb begin
    fall_d = (clear || changed) ? 1'b0 : (~sel & lvl_q);
  end

  always_ff @(posedge clk) begin
    if (reset) fall_q <= 1'b0;
    else       fall_q <= fall_d;
  end

  assign tick_fall = fall_q;
`else
  assign tick_fall = 1'b0;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// Prescaler + free-running counter feeding NCH tap-selected tick channels.
// Define TICKGEN_FALL_EN to build the falling-edge strobes on tick_fall.
module tick_gen_multi
  import tick_gen_multi_pkg::*;
#(
  parameter int PREDIV = DEF_PREDIV,
  parameter int PRE_W  = 8,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int NCH    = 3,
  parameter int TAP_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PRE_W-1:0]     div_in,
  input  logic                 div_load,
  input  logic                 sync,
  input  logic [NCH*TAP_W-1:0] tap_sel,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       lvl,
  output logic [NCH-1:0]       tick_fall
);

  logic [PRE_W-1:0] div_d, div_q;
  logic [PRE_W-1:0] pre_cnt_d, pre_cnt_q;
  logic [PRE_W-1:0] div_eff;
  logic [PRE_W-1:0] reload;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ce;

  // Reload always uses the registered divisor, so a load mid-period only
  // takes effect at the following reload (including a same-cycle sync).
  always_comb begin
    div_eff   = (div_q < PRE_W'(DIV_MIN)) ? PRE_W'(DIV_MIN) : div_q;
    reload    = div_eff - PRE_W'(1);
    ce        = (pre_cnt_q == '0);
    div_d     = div_load ? div_in : div_q;
    pre_cnt_d = pre_cnt_q - PRE_W'(1);
    cnt_d     = cnt_q;
    if (sync) begin
      pre_cnt_d = reload;
      cnt_d     = '0;
    end else if (ce) begin
      pre_cnt_d = reload;
      cnt_d     = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= PRE_W'(PREDIV);
      pre_cnt_q <= PRE_W'(PREDIV - 1);
      cnt_q     <= '0;
    end else begin
      div_q     <= div_d;
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    tick_chan #(
      .CNT_W (CNT_W),
      .TAP_W (TAP_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .clear     (sync),
      .cnt       (cnt_q),
      .tap       (tap_sel[tap_lo(i, TAP_W) +: TAP_W]),
      .tick      (tick[i]),
      .lvl       (lvl[i]),
      .tick_fall (tick_fall[i])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi (div 4, 8-bit counter, 2 channels) plus a
// 6-bit-counter instance for disabled taps.
module tb_tick_gen_multi;

  localparam int PRE_W = 8;
  localparam int NCH   = 2;
  localparam int TAP_W = 3;

`ifdef TICKGEN_FALL_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 sync;
  logic                 div_load;
  logic [PRE_W-1:0]     div_in;
  logic [NCH*TAP_W-1:0] tap_sel;
  logic [NCH*TAP_W-1:0] tap_sel_b;
  logic [NCH-1:0]       tick, lvl, tick_fall;
  logic [NCH-1:0]       tick_b, lvl_b, fall_b;

  tick_gen_multi #(.PREDIV(4), .PRE_W(PRE_W), .CNT_W(8), .NCH(NCH), .TAP_W(TAP_W)) dut (
    .clk(clk), .reset(reset), .div_in(div_in), .div_load(div_load), .sync(sync),
    .tap_sel(tap_sel), .tick(tick), .lvl(lvl), .tick_fall(tick_fall)
  );

  tick_gen_multi #(.PREDIV(4), .PRE_W(PRE_W), .CNT_W(6), .NCH(NCH), .TAP_W(TAP_W)) dut_b (
    .clk(clk), .reset(reset), .div_in(div_in), .div_load(div_load), .sync(sync),
    .tap_sel(tap_sel_b), .tick(tick_b), .lvl(lvl_b), .tick_fall(fall_b)
  );

  typedef struct {
    int         n;
    logic [1:0] tick;
    logic [1:0] lvl;
    logic [1:0] fall;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   edgeNum    = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s @edge %0d: got %0d, expected %0d", name, edgeNum, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    edgeNum++;
  endtask

  initial begin
    int         cnt1;
    int         last1;
    bit         bAny;
    logic [1:0] expFall;

    reset     = 1'b1;
    sync      = 1'b0;
    div_load  = 1'b0;
    div_in    = '0;
    tap_sel   = {3'd7, 3'd0};
    tap_sel_b = {3'd7, 3'd6};

    // Edge n after release: counter = n/4, tick0 at n%8==5, fall0 at n%8==1 (n>=9).
    vecs.push_back('{0,  2'b00, 2'b00, 2'b00});
    vecs.push_back('{1,  2'b00, 2'b00, 2'b00});
    vecs.push_back('{4,  2'b00, 2'b00, 2'b00});
    vecs.push_back('{5,  2'b01, 2'b01, 2'b00});
    vecs.push_back('{6,  2'b00, 2'b01, 2'b00});
    vecs.push_back('{8,  2'b00, 2'b01, 2'b00});
    vecs.push_back('{9,  2'b00, 2'b00, 2'b01});
    vecs.push_back('{12, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{13, 2'b01, 2'b01, 2'b00});
    vecs.push_back('{14, 2'b00, 2'b01, 2'b00});
    vecs.push_back('{17, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{21, 2'b01, 2'b01, 2'b00});
    vecs.push_back('{22, 2'b00, 2'b01, 2'b00});

    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    edgeNum = 0;

    foreach (vecs[i]) begin
      while (edgeNum < vecs[i].n) applyStimulus();
      expFall = FALL_EN ? vecs[i].fall : 2'b00;
      checkOutput("tbl_tick", 32'(tick), 32'(vecs[i].tick));
      checkOutput("tbl_lvl", 32'(lvl), 32'(vecs[i].lvl));
      checkOutput("tbl_fall", 32'(tick_fall), 32'(expFall));
    end

    // Tap 7 on an 8-bit counter at div 4: pulses at 513 + k*1024, wrap adds none.
    cnt1  = 0;
    last1 = 0;
    bAny  = 1'b0;
    while (edgeNum < 3600) begin
      applyStimulus();
      if (tick[1]) begin
        if (cnt1 == 0) checkOutput("tick1_first", 32'(edgeNum), 32'd513);
        else           checkOutput("tick1_spacing", 32'(edgeNum - last1), 32'd1024);
        last1 = edgeNum;
        cnt1++;
      end
      if (|{tick_b, lvl_b, fall_b}) bAny = 1'b1;
    end
    checkOutput("tick1_count", 32'(cnt1), 32'd4);
    checkOutput("disabled_taps_quiet", 32'(bAny), 32'd0);

    // Sync with both levels high; next tick0 must land 5 edges later.
    while (edgeNum < 3605) applyStimulus();
    checkOutput("lvl_pre_sync", 32'(lvl), 32'd3);
    sync = 1'b1;
    applyStimulus();
    sync = 1'b0;
    checkOutput("sync_tick", 32'(tick), 32'd0);
    checkOutput("sync_lvl", 32'(lvl), 32'd0);

    // Load 10 mid-period at m=6, then 0 at m=60 (every-cycle ce from m=68).
    for (int m = 1; m <= 80; m++) begin
      if (m == 6) begin
        div_in   = 8'd10;
        div_load = 1'b1;
      end else if (m == 60) begin
        div_in   = 8'd0;
        div_load = 1'b1;
      end else begin
        div_load = 1'b0;
      end
      applyStimulus();
      checkOutput("div_tick0", 32'(tick[0]),
                  32'(m inside {5, 19, 39, 59, 70, 72, 74, 76, 78, 80}));
    end
    div_load = 1'b0;

    // Sync with a same-cycle load of 4: first reload still uses old div (0 -> 1).
    sync     = 1'b1;
    div_in   = 8'd4;
    div_load = 1'b1;
    applyStimulus();
    sync     = 1'b0;
    div_load = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 7) tap_sel = {3'd7, 3'd1};
      applyStimulus();
      checkOutput("tap_tick0", 32'(tick[0]), 32'(k == 2 || k == 22));
      checkOutput("tap_fall0", 32'(tick_fall[0]), 32'(FALL_EN && (k == 6 || k == 14)));
      if (k == 7) checkOutput("tap_lvl0_updates", 32'(lvl[0]), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
